// File: rtl/out_layer_seq.sv
// Edge-serial output layer for the min-sum LDPC decoder: accumulates check-to-variable messages
// onto channel LLRs one edge per clock, then emits clamped a-posteriori LLRs and hard decisions.
module out_layer_seq #(
  parameter int unsigned N_V = 44,
  parameter int unsigned E   = 147,
  parameter int unsigned W   = 8,
  parameter int unsigned AW  = 16,
  parameter int unsigned VW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [VW-1:0]       tanner_v [0:E-1],
  input  logic signed [W-1:0] llr      [0:N_V-1],
  input  logic signed [W-1:0] msg      [0:E-1],
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic signed [W-1:0] out_llr  [0:N_V-1],
  output logic                hard     [0:N_V-1]
);

  localparam int unsigned EW = (E > 1) ? $clog2(E) : 1;
  localparam logic [EW-1:0] ELast = EW'(E - 1);

  // Symmetric limits: the most negative code of either width is never produced.
  localparam logic signed [AW:0]   SumMax = (AW+1)'((1 << (AW-1)) - 1);
  localparam logic signed [AW:0]   SumMin = -SumMax;
  localparam logic signed [AW-1:0] OutMax = AW'((1 << (W-1)) - 1);
  localparam logic signed [AW-1:0] OutMin = -OutMax;

  typedef enum logic [1:0] {StIdle, StLoad, StAccum, StFin} state_e;

  state_e                state_q, state_d;
  logic [EW-1:0]         e_q, e_d;
  logic signed [AW-1:0]  acc_q [N_V];
  logic signed [AW-1:0]  acc_d [N_V];
  logic signed [W-1:0]   out_llr_q [N_V];
  logic signed [W-1:0]   out_llr_d [N_V];
  logic                  hard_q [N_V];
  logic                  hard_d [N_V];
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  hit;
  logic signed [AW-1:0]  acc_sel;
  logic signed [AW-1:0]  acc_new;

  function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a,
                                                   input logic signed [W-1:0]  b);
    logic signed [AW:0] s;
    s = $signed({a[AW-1], a}) + $signed({{(AW+1-W){b[W-1]}}, b});
    if (s > SumMax) s = SumMax;
    else if (s < SumMin) s = SumMin;
    return s[AW-1:0];
  endfunction

  function automatic logic signed [W-1:0] clamp_out(input logic signed [AW-1:0] a);
    if (a > OutMax) return OutMax[W-1:0];
    if (a < OutMin) return OutMin[W-1:0];
    return a[W-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    acc_d     = acc_q;
    out_llr_d = out_llr_q;
    hard_d    = hard_q;
    done_d    = 1'b0;
    err_d     = err_q;

    // Decode the current edge's target; an index with no match is an invalid edge.
    hit     = 1'b0;
    acc_sel = '0;
    for (int v = 0; v < int'(N_V); v++) begin
      if (tanner_v[e_q] == VW'(v)) begin
        hit     = 1'b1;
        acc_sel = acc_q[v];
      end
    end
    acc_new = sat_add(acc_sel, msg[e_q]);

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        for (int v = 0; v < int'(N_V); v++) begin
          acc_d[v] = {{(AW-W){llr[v][W-1]}}, llr[v]};
        end
        e_d     = '0;
        state_d = StAccum;
      end
      StAccum: begin
        if (hit) begin
          for (int v = 0; v < int'(N_V); v++) begin
            if (tanner_v[e_q] == VW'(v)) acc_d[v] = acc_new;
          end
        end else begin
          err_d = 1'b1;
        end
        if (e_q == ELast) state_d = StFin;
        else e_d = e_q + 1'b1;
      end
      StFin: begin
        for (int v = 0; v < int'(N_V); v++) begin
          out_llr_d[v] = clamp_out(acc_q[v]);
          hard_d[v]    = out_llr_d[v][W-1];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      e_q       <= '0;
      acc_q     <= '{default: '0};
      out_llr_q <= '{default: '0};
      hard_q    <= '{default: 1'b0};
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      acc_q     <= acc_d;
      out_llr_q <= out_llr_d;
      hard_q    <= hard_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign err     = err_q;
  assign out_llr = out_llr_q;
  assign hard    = hard_q;

endmodule

// File: tb/tb_out_layer_seq.sv
// Scoreboard bench for out_layer_seq on a 4-variable, 6-edge graph.
module tb_out_layer_seq;

  localparam int N_V = 4;
  localparam int E   = 6;
  localparam int W   = 8;
  localparam int AW  = 16;
  localparam int VW  = 8;
  localparam int PW  = N_V * W + N_V + 1;

  typedef logic [PW-1:0] res_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [VW-1:0]       tv      [0:E-1];
  logic signed [W-1:0] llr     [0:N_V-1];
  logic signed [W-1:0] msg     [0:E-1];
  logic                busy;
  logic                done;
  logic                err;
  logic signed [W-1:0] out_llr [0:N_V-1];
  logic                hard    [0:N_V-1];

  res_t exp_q[$];
  res_t obs_q[$];
  res_t got, want;
  int   done_cnt = 0;
  int   cyc_now  = 0;
  int   k_cyc    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  out_layer_seq #(.N_V(N_V), .E(E), .W(W), .AW(AW), .VW(VW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tanner_v (tv),
    .llr      (llr),
    .msg      (msg),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .out_llr  (out_llr),
    .hard     (hard)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  function automatic res_t pack_dut();
    res_t r = '0;
    for (int v = 0; v < N_V; v++) begin
      r[v*W +: W]   = out_llr[v];
      r[N_V*W + v]  = hard[v];
    end
    r[PW-1] = err;
    return r;
  endfunction

  // Reference: integer accumulation with saturation at AW bits, then clamp to W bits.
  function automatic res_t model();
    res_t r = '0;
    int   acc [N_V];
    int   s, idx, o;
    bit   bad = 1'b0;
    for (int v = 0; v < N_V; v++) acc[v] = int'(llr[v]);
    for (int e = 0; e < E; e++) begin
      idx = int'(tv[e]);
      if (idx < N_V) begin
        s = acc[idx] + int'(msg[e]);
        if (s > 32767) s = 32767;
        if (s < -32767) s = -32767;
        acc[idx] = s;
      end else begin
        bad = 1'b1;
      end
    end
    for (int v = 0; v < N_V; v++) begin
      o = acc[v];
      if (o > 127) o = 127;
      if (o < -127) o = -127;
      r[v*W +: W]  = o[W-1:0];
      r[N_V*W + v] = (o < 0);
    end
    r[PW-1] = bad;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      obs_q.push_back(pack_dut());
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic set_basic();
    tv  = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
    llr = '{8'sd5, -8'sd3, 8'sd0, 8'sd10};
    msg = '{8'sd1, 8'sd2, -8'sd4, 8'sd7, -8'sd20, 8'sd6};
  endtask

  // Returns with the sample point just after edge k (the edge that samples start).
  task automatic do_start(input bit hold);
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(model());
    @(posedge clk);
    #1;
    k_cyc = cyc_now;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_hi);
    lat     = -1;
    busy_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = cyc_now - k_cyc;
        break;
      end
      if (busy) busy_hi++;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    set_basic();
    #2;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++;
    if (pack_dut() !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", pack_dut()); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bh;
    int exp_llr [N_V] = '{8, -7, 7, -4};
    bit exp_hard [N_V] = '{1'b0, 1'b1, 1'b0, 1'b1};
    set_basic();
    do_start(1'b0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_k: got %b want 1", busy); end
    wait_done(lat, bh);
    n_checks++;
    if (lat != E + 2) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, E + 2); end
    n_checks++;
    if (bh != E + 1) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", bh, E + 1); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b want 0", busy); end
    for (int v = 0; v < N_V; v++) begin
      n_checks++;
      if (int'(out_llr[v]) != exp_llr[v] || hard[v] !== exp_hard[v]) begin
        n_fail++;
        $display("FAIL basic_v%0d: got llr=%0d hard=%b want llr=%0d hard=%b",
                 v, out_llr[v], hard[v], exp_llr[v], exp_hard[v]);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL basic_sb: got %0d results want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin n_fail++; $display("FAIL basic_sb: got %h want %h", got, want); end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_saturation();
    int lat, bh;
    set_basic();
    llr[0] = 8'sd100; msg[0] = 8'sd100; msg[1] = 8'sd100;
    llr[3] = 8'sh80;  msg[4] = 8'sh80;  msg[5] = 8'sh80;
    do_start(1'b0);
    wait_done(lat, bh);
    n_checks++;
    if (lat != E + 2) begin n_fail++; $display("FAIL sat_latency: got %0d want %0d", lat, E + 2); end
    n_checks++;
    if (int'(out_llr[0]) != 127 || hard[0] !== 1'b0) begin
      n_fail++; $display("FAIL sat_pos: got %0d/%b want 127/0", out_llr[0], hard[0]);
    end
    n_checks++;
    if (int'(out_llr[3]) != -127 || hard[3] !== 1'b1) begin
      n_fail++; $display("FAIL sat_neg: got %0d/%b want -127/1", out_llr[3], hard[3]);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL sat_sb: got %0d results want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin n_fail++; $display("FAIL sat_sb: got %h want %h", got, want); end
    end
  endtask

  task automatic test_invalid();
    int lat, bh;
    set_basic();
    tv[2] = 8'd7;
    do_start(1'b0);
    wait_done(lat, bh);
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL inv_err: got %b want 1", err); end
    n_checks++;
    if (int'(out_llr[1]) != -3) begin n_fail++; $display("FAIL inv_llr1: got %0d want -3", out_llr[1]); end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL inv_sb: got %0d results want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin n_fail++; $display("FAIL inv_sb: got %h want %h", got, want); end
    end
    set_basic();
    do_start(1'b0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL inv_err_clear: got %b want 0", err); end
    wait_done(lat, bh);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL inv_err_next: got %b want 0", err); end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL inv_next_sb: got %0d results want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin n_fail++; $display("FAIL inv_next_sb: got %h want %h", got, want); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bh, d0;
    set_basic();
    do_start(1'b0);
    repeat (4) @(posedge clk);
    rst  = 1'b0;
    want = exp_q.pop_back();
    d0   = done_cnt;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ctrl: got busy=%b done=%b want 0 0", busy, done);
    end
    n_checks++;
    if (pack_dut() !== '0) begin n_fail++; $display("FAIL rmid_out: got %h want 0", pack_dut()); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (E + 4) @(posedge clk);
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL rmid_no_done: got %0d want %0d", done_cnt, d0); end
    do_start(1'b0);
    wait_done(lat, bh);
    n_checks++;
    if (lat != E + 2) begin n_fail++; $display("FAIL rmid_latency: got %0d want %0d", lat, E + 2); end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL rmid_sb: got %0d results want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin n_fail++; $display("FAIL rmid_sb: got %h want %h", got, want); end
    end
  endtask

  task automatic test_handshake();
    int lat, lat2, bh, d0, d_cyc;
    set_basic();
    d0 = done_cnt;
    do_start(1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bh);
    n_checks++;
    if (lat != E + 2) begin n_fail++; $display("FAIL hs_ignore_latency: got %0d want %0d", lat, E + 2); end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL hs_ignore_sb: got %0d results want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin n_fail++; $display("FAIL hs_ignore_sb: got %h want %h", got, want); end
    end
    repeat (E + 6) @(posedge clk);
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL hs_ignore_count: got %0d want 1", done_cnt - d0); end

    // Held start: the second pass is sampled on the edge that ends the first done cycle.
    llr[2] = -8'sd9;
    do_start(1'b1);
    exp_q.push_back(model());
    wait_done(lat, bh);
    n_checks++;
    if (lat != E + 2) begin n_fail++; $display("FAIL hs_hold_first: got %0d want %0d", lat, E + 2); end
    d_cyc = cyc_now;
    @(posedge clk);
    #1;
    start = 1'b0;
    k_cyc = d_cyc;
    wait_done(lat2, bh);
    n_checks++;
    if (lat2 != E + 3) begin n_fail++; $display("FAIL hs_hold_period: got %0d want %0d", lat2, E + 3); end
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        n_fail++; $display("FAIL hs_hold_sb%0d: got %0d results want 1", i, obs_q.size());
      end else begin
        got = obs_q.pop_front(); want = exp_q.pop_front();
        if (got !== want) begin n_fail++; $display("FAIL hs_hold_sb%0d: got %h want %h", i, got, want); end
      end
    end
  endtask

  task automatic test_zero();
    int lat, bh;
    set_basic();
    llr = '{default: 8'sd0};
    msg = '{default: 8'sd0};
    do_start(1'b0);
    wait_done(lat, bh);
    for (int v = 0; v < N_V; v++) begin
      n_checks++;
      if (out_llr[v] !== 8'sd0 || hard[v] !== 1'b0) begin
        n_fail++; $display("FAIL zero_v%0d: got %0d/%b want 0/0", v, out_llr[v], hard[v]);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL zero_sb: got %0d results want 1", obs_q.size());
    end else begin
      got = obs_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin n_fail++; $display("FAIL zero_sb: got %h want %h", got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_invalid();
    test_reset_mid();
    test_handshake();
    test_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
